// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg
// Shared helpers for the FIR output stage: address-width calculation,
// saturation limits for a signed width, and the round-half-up constant for
// a given fractional right shift. All functions are elaboration-time only.
// ---------------------------------------------------------------------------
package fir_pkg;

   // Smallest r such that 2**r >= n.
   function automatic int clogb2(input int n);
      int r;
      for (r = 0; (1 << r) < n; r++) begin
      end
      return r;
   endfunction

   // Largest value representable in a w-bit two's-complement number.
   function automatic longint sat_max(input int w);
      return (longint'(1) << (w - 1)) - 1;
   endfunction

   // Smallest value representable in a w-bit two's-complement number.
   function automatic longint sat_min(input int w);
      return -(longint'(1) << (w - 1));
   endfunction

   // Half an output LSB, added before the arithmetic shift.
   function automatic longint round_const(input int shift);
      return longint'(1) << (shift - 1);
   endfunction

endpackage

// File: rtl/fir_decim_out_if.sv
// ---------------------------------------------------------------------------
// fir_decim_out_if
// Stream signals of the FIR output stage.
//   s_axis_data_*  : valid-only accumulator stream from the MAC chain
//   m_axis_data_*  : AXI4-Stream output with valid/ready handshake
// Modports:
//   slave  : the fir_decim_out block (consumes s_axis, produces m_axis)
//   master : the surrounding environment (produces s_axis, consumes m_axis)
// ---------------------------------------------------------------------------
interface fir_decim_out_if #(
   parameter int C_S_DATA_TDATA_WIDTH = 32,
   parameter int C_M_DATA_TDATA_WIDTH = 16
);
   logic                                   s_axis_data_tvalid;
   logic signed [C_S_DATA_TDATA_WIDTH-1:0] s_axis_data_tdata;
   logic                                   m_axis_data_tvalid;
   logic                                   m_axis_data_tready;
   logic        [C_M_DATA_TDATA_WIDTH-1:0] m_axis_data_tdata;

   modport slave (
      input  s_axis_data_tvalid,
      input  s_axis_data_tdata,
      output m_axis_data_tvalid,
      input  m_axis_data_tready,
      output m_axis_data_tdata
   );

   modport master (
      output s_axis_data_tvalid,
      output s_axis_data_tdata,
      input  m_axis_data_tvalid,
      output m_axis_data_tready,
      input  m_axis_data_tdata
   );
endinterface

// File: rtl/fir_out_fifo.sv
// ---------------------------------------------------------------------------
// fir_out_fifo
// First-word-fall-through synchronous FIFO.
// Ports:
//   aclk, aresetn : clock, asynchronous active-low reset
//   wr_en, din    : push din (ignored when full unless rd_en on the same edge)
//   rd_en         : pop head word (ignored when empty)
//   dout          : head word while not empty, zero when empty
//   empty, full   : occupancy status
// ---------------------------------------------------------------------------
module fir_out_fifo
   import fir_pkg::*;
#(
   parameter int C_WIDTH = 16,
   parameter int C_DEPTH = 4
) (
   input  logic               aclk,
   input  logic               aresetn,
   input  logic               wr_en,
   input  logic [C_WIDTH-1:0] din,
   input  logic               rd_en,
   output logic [C_WIDTH-1:0] dout,
   output logic               empty,
   output logic               full
);
   localparam int            AW       = clogb2(C_DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW + 1)'(C_DEPTH);

   logic [C_WIDTH-1:0] mem [C_DEPTH];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [AW:0]        count;
   logic               wr_ok;
   logic               rd_ok;

   assign empty = (count == '0);
   assign full  = (count == CNT_FULL);
   assign rd_ok = rd_en && !empty;
   // When full, a write is only safe if the head slot is freed on this edge.
   assign wr_ok = wr_en && (!full || rd_ok);
   // Zero while empty so stale storage never shows after reset.
   assign dout  = empty ? '0 : mem[rd_ptr];

   // NOTE: storage is deliberately not reset; occupancy alone defines which
   // words are meaningful, and an unreset array maps onto plain RAM/flops.
   always_ff @(posedge aclk) begin
      if (wr_ok) mem[wr_ptr] <= din;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
         if (wr_ok && !rd_ok)      count <= count + CNT_ONE;
         else if (!wr_ok && rd_ok) count <= count - CNT_ONE;
      end
   end
endmodule

// File: rtl/fir_decim_out.sv
// ---------------------------------------------------------------------------
// fir_decim_out
// Output stage after the FIR MAC chain: decimate by a runtime factor, round
// half-up, saturate to the output width, and buffer in a FWFT FIFO so the
// consumer sees an AXI4-Stream valid/ready handshake.
// Ports:
//   aclk, aresetn : clock, asynchronous active-low reset
//   axis          : fir_decim_out_if.slave (s_axis_data_* in, m_axis_data_* out)
//   cfg_decim     : decimation factor D, 0 treated as 1, latched on kept beats
//   clr_status    : synchronous clear of the sticky flags
//   sat_flag      : sticky, a kept sample was clamped
//   drop_flag     : sticky, a result was discarded because the FIFO was full
// ---------------------------------------------------------------------------
module fir_decim_out
   import fir_pkg::*;
#(
   parameter int C_S_DATA_TDATA_WIDTH = 32,
   parameter int C_M_DATA_TDATA_WIDTH = 16,
   parameter int C_FRAC_SHIFT         = 15,
   parameter int C_DECIM_WIDTH        = 4,
   parameter int C_FIFO_DEPTH         = 4
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   fir_decim_out_if.slave           axis,
   input  logic [C_DECIM_WIDTH-1:0] cfg_decim,
   input  logic                     clr_status,
   output logic                     sat_flag,
   output logic                     drop_flag
);
   localparam int SW = C_S_DATA_TDATA_WIDTH + 1;             // rounding sum
   localparam int YW = C_S_DATA_TDATA_WIDTH + 1 - C_FRAC_SHIFT; // after shift
   localparam int MW = C_M_DATA_TDATA_WIDTH;

   localparam logic signed [SW-1:0]        RND   = SW'(round_const(C_FRAC_SHIFT));
   localparam logic signed [YW-1:0]        Y_MAX = YW'(sat_max(MW));
   localparam logic signed [YW-1:0]        Y_MIN = YW'(sat_min(MW));
   localparam logic [C_DECIM_WIDTH-1:0]    D_ONE = C_DECIM_WIDTH'(1);

   logic [C_DECIM_WIDTH-1:0] ph;
   logic [C_DECIM_WIDTH-1:0] d_act;
   logic [C_DECIM_WIDTH-1:0] d_cfg;
   logic [C_DECIM_WIDTH-1:0] next_d;
   logic                     keep;
   logic signed [SW-1:0]     sum;
   logic signed [YW-1:0]     y;
   logic [MW-1:0]            y_sat;
   logic                     clamp;
   logic                     r_vld;
   logic [MW-1:0]            r_data;
   logic                     pop;
   logic                     drop;
   logic                     fifo_empty;
   logic                     fifo_full;
   logic [MW-1:0]            fifo_dout;

   // NOTE: every signal driven here gets a default first so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      d_cfg  = (cfg_decim == '0) ? D_ONE : cfg_decim;
      keep   = axis.s_axis_data_tvalid && (ph == '0);
      // A kept beat starts a new period with the freshly latched factor.
      next_d = keep ? d_cfg : d_act;

      sum    = SW'(axis.s_axis_data_tdata) + RND;
      y      = YW'(sum >>> C_FRAC_SHIFT);
      clamp  = 1'b0;
      y_sat  = MW'(y);
      if (y > Y_MAX) begin
         y_sat = MW'(Y_MAX);
         clamp = 1'b1;
      end else if (y < Y_MIN) begin
         y_sat = MW'(Y_MIN);
         clamp = 1'b1;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         ph    <= '0;
         d_act <= D_ONE;
      end else if (axis.s_axis_data_tvalid) begin
         ph <= (ph == next_d - D_ONE) ? '0 : ph + D_ONE;
         if (keep) d_act <= d_cfg;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_vld  <= 1'b0;
         r_data <= '0;
      end else begin
         r_vld <= keep;
         if (keep) r_data <= y_sat;
      end
   end

   assign pop  = axis.m_axis_data_tvalid && axis.m_axis_data_tready;
   assign drop = r_vld && fifo_full && !pop;

   // Set events take priority over a coincident clear.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         sat_flag  <= 1'b0;
         drop_flag <= 1'b0;
      end else begin
         if (keep && clamp) sat_flag <= 1'b1;
         else if (clr_status) sat_flag <= 1'b0;
         if (drop) drop_flag <= 1'b1;
         else if (clr_status) drop_flag <= 1'b0;
      end
   end

   fir_out_fifo #(
      .C_WIDTH (MW),
      .C_DEPTH (C_FIFO_DEPTH)
   ) u_fifo (
      .aclk    (aclk),
      .aresetn (aresetn),
      .wr_en   (r_vld && !drop),
      .din     (r_data),
      .rd_en   (pop),
      .dout    (fifo_dout),
      .empty   (fifo_empty),
      .full    (fifo_full)
   );

   assign axis.m_axis_data_tvalid = !fifo_empty;
   assign axis.m_axis_data_tdata  = fifo_dout;
endmodule

// File: tb/tb_fir_decim_out.sv
// ---------------------------------------------------------------------------
// tb_fir_decim_out
// Directed scenarios followed by randomized traffic. A reference model
// predicts each kept, rounded, saturated sample and FIFO acceptance; a
// monitor compares DUT output beats and flags against it.
// ---------------------------------------------------------------------------
module tb_fir_decim_out;
   localparam int SW    = 32;
   localparam int MW    = 16;
   localparam int SH    = 15;
   localparam int DW    = 4;
   localparam int DEPTH = 4;

   logic          aclk    = 1'b0;
   logic          aresetn = 1'b0;
   logic [DW-1:0] cfg_decim;
   logic          clr_status;
   logic          sat_flag;
   logic          drop_flag;

   always #5 aclk = ~aclk;

   fir_decim_out_if #(
      .C_S_DATA_TDATA_WIDTH (SW),
      .C_M_DATA_TDATA_WIDTH (MW)
   ) vif ();

   fir_decim_out #(
      .C_S_DATA_TDATA_WIDTH (SW),
      .C_M_DATA_TDATA_WIDTH (MW),
      .C_FRAC_SHIFT         (SH),
      .C_DECIM_WIDTH        (DW),
      .C_FIFO_DEPTH         (DEPTH)
   ) dut (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .axis       (vif),
      .cfg_decim  (cfg_decim),
      .clr_status (clr_status),
      .sat_flag   (sat_flag),
      .drop_flag  (drop_flag)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Scoreboard: samples the FIFO should currently hold, oldest first.
   logic [MW-1:0] exp_q[$];
   bit            popped_pending;
   int            skip_left;
   bit            st_vld;
   logic [MW-1:0] st_val;
   bit            exp_sat;
   bit            exp_drop;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Round half toward +inf, then clamp to the signed output range.
   function automatic logic [MW-1:0] ref_out(input logic signed [SW-1:0] x, output bit sat);
      longint v;
      longint hi;
      longint lo;
      hi  = (longint'(1) << (MW - 1)) - 1;
      lo  = -(longint'(1) << (MW - 1));
      v   = (longint'(x) + (longint'(1) << (SH - 1))) >>> SH;
      sat = 1'b0;
      if (v > hi) begin v = hi; sat = 1'b1; end
      if (v < lo) begin v = lo; sat = 1'b1; end
      return MW'(v);
   endfunction

   // Reference model: one sample kept every D input beats, one-cycle stage
   // delay, then acceptance into a DEPTH-entry buffer.
   always @(posedge aclk or negedge aresetn) begin : model
      bit            pop;
      bit            drop_evt;
      bit            sat_evt;
      bit            s;
      if (!aresetn) begin
         exp_q.delete();
         popped_pending = 1'b0;
         skip_left      = 0;
         st_vld         = 1'b0;
         exp_sat        = 1'b0;
         exp_drop       = 1'b0;
      end else begin
         pop            = popped_pending;
         popped_pending = 1'b0;
         drop_evt       = 1'b0;
         if (st_vld) begin
            if (!pop && exp_q.size() == DEPTH) drop_evt = 1'b1;
            else exp_q.push_back(st_val);
         end
         sat_evt = 1'b0;
         st_vld  = 1'b0;
         if (vif.s_axis_data_tvalid) begin
            if (skip_left == 0) begin
               skip_left = (cfg_decim == '0) ? 0 : int'(cfg_decim) - 1;
               st_val    = ref_out(vif.s_axis_data_tdata, s);
               sat_evt   = s;
               st_vld    = 1'b1;
            end else begin
               skip_left--;
            end
         end
         exp_sat  = sat_evt  ? 1'b1 : (clr_status ? 1'b0 : exp_sat);
         exp_drop = drop_evt ? 1'b1 : (clr_status ? 1'b0 : exp_drop);
      end
   end

   // Monitor: compare on the falling edge, away from the active edge.
   always @(negedge aclk) begin
      if (aresetn) begin
         check("tvalid", 64'(vif.m_axis_data_tvalid), 64'(exp_q.size() != 0));
         check("sat_flag", 64'(sat_flag), 64'(exp_sat));
         check("drop_flag", 64'(drop_flag), 64'(exp_drop));
         if (vif.m_axis_data_tvalid && vif.m_axis_data_tready && exp_q.size() != 0) begin
            check("tdata", 64'(vif.m_axis_data_tdata), 64'(exp_q.pop_front()));
            popped_pending = 1'b1;
         end
      end
   end

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic beat(input logic [SW-1:0] d);
      vif.s_axis_data_tvalid = 1'b1;
      vif.s_axis_data_tdata  = d;
      tick();
      vif.s_axis_data_tvalid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic clear_flags();
      clr_status = 1'b1;
      tick();
      clr_status = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      vif.s_axis_data_tvalid = 1'b0;
      vif.s_axis_data_tdata  = '0;
      vif.m_axis_data_tready = 1'b1;
      cfg_decim              = DW'(1);
      clr_status             = 1'b0;

      // Reset state
      #12;
      check("rst_tvalid", 64'(vif.m_axis_data_tvalid), 0);
      check("rst_tdata", 64'(vif.m_axis_data_tdata), 0);
      check("rst_sat", 64'(sat_flag), 0);
      check("rst_drop", 64'(drop_flag), 0);
      @(negedge aclk);
      aresetn = 1'b1;
      tick();

      // D=1 rounding and two-cycle latency
      beat(32'h0000_8000);
      check("lat_e0_tvalid", 64'(vif.m_axis_data_tvalid), 0);
      beat(32'h0000_4000);
      check("lat_e1_tvalid", 64'(vif.m_axis_data_tvalid), 1);
      check("lat_e1_tdata", 64'(vif.m_axis_data_tdata), 64'h0001);
      beat(32'hFFFF_8000);
      tick();
      check("neg_tdata", 64'(vif.m_axis_data_tdata), 64'hFFFF);
      idle(4);

      // D=3, then a mid-period change to 2, then D=0 behaving as 1
      cfg_decim = DW'(3);
      for (int k = 1; k <= 9; k++) beat(32'(k) << 15);
      idle(4);
      cfg_decim = DW'(3);
      for (int k = 1; k <= 9; k++) begin
         if (k == 3) cfg_decim = DW'(2);
         beat(32'(k) << 15);
      end
      cfg_decim = '0;
      for (int k = 1; k <= 3; k++) beat(32'(k * 10) << 15);
      idle(4);

      // Saturation and sticky-flag clear priority
      cfg_decim = DW'(1);
      beat(32'h7FFF_FFFF);
      beat(32'h8000_0000);
      tick();
      check("sat_set", 64'(sat_flag), 1);
      clear_flags();
      check("sat_clr", 64'(sat_flag), 0);
      clr_status = 1'b1;
      beat(32'h7FFF_FFFF);
      clr_status = 1'b0;
      check("sat_clr_vs_set", 64'(sat_flag), 1);
      clear_flags();
      idle(4);

      // Backpressure: six kept beats into a four-entry buffer
      vif.m_axis_data_tready = 1'b0;
      for (int k = 1; k <= 6; k++) beat(32'(k) << 15);
      idle(2);
      check("bp_drop", 64'(drop_flag), 1);
      check("bp_head", 64'(vif.m_axis_data_tdata), 64'h0001);
      vif.m_axis_data_tready = 1'b1;
      idle(6);
      clear_flags();
      idle(2);

      // Full buffer with pop and write on the same edge
      vif.m_axis_data_tready = 1'b0;
      for (int k = 1; k <= 4; k++) beat(32'(k * 100) << 15);
      idle(2);
      beat(32'(500) << 15);
      vif.m_axis_data_tready = 1'b1;
      tick();
      check("full_pop_drop", 64'(drop_flag), 0);
      idle(8);

      // Asynchronous reset mid-stream with the buffer half full
      vif.m_axis_data_tready = 1'b0;
      beat(32'h7FFF_FFFF);
      beat(32'(2) << 15);
      idle(2);
      cfg_decim = DW'(3);
      #3;
      aresetn = 1'b0;
      #1;
      check("arst_tvalid", 64'(vif.m_axis_data_tvalid), 0);
      check("arst_tdata", 64'(vif.m_axis_data_tdata), 0);
      check("arst_sat", 64'(sat_flag), 0);
      check("arst_drop", 64'(drop_flag), 0);
      @(negedge aclk);
      aresetn = 1'b1;
      tick();
      vif.m_axis_data_tready = 1'b1;
      beat(32'(3) << 15);
      check("post_rst_e0_tvalid", 64'(vif.m_axis_data_tvalid), 0);
      tick();
      check("post_rst_e1_tvalid", 64'(vif.m_axis_data_tvalid), 1);
      check("post_rst_e1_tdata", 64'(vif.m_axis_data_tdata), 64'h0003);
      for (int k = 4; k <= 9; k++) beat(32'(k) << 15);
      idle(4);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 49) == 0) cfg_decim = DW'($urandom_range(0, 15));
         vif.s_axis_data_tvalid = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 3) == 0) vif.s_axis_data_tdata = $urandom;
         else vif.s_axis_data_tdata = SW'(int'($urandom_range(0, 2 ** 21)) - 2 ** 20);
         vif.m_axis_data_tready = ($urandom_range(0, 9) < 6);
         clr_status             = ($urandom_range(0, 49) == 0);
         tick();
      end
      vif.s_axis_data_tvalid = 1'b0;
      clr_status             = 1'b0;
      vif.m_axis_data_tready = 1'b1;

      // Drain with a bounded wait
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
      check("drain_remaining", 64'(exp_q.size()), 0);
      idle(2);
      check("drain_tvalid", 64'(vif.m_axis_data_tvalid), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
